// File: rtl/cordic_ci_sequencer.sv
// cordic_ci_sequencer
// Multi-cycle Nios II custom-instruction front end for the shared iterative
// cosine CORDIC core. The float operand is converted to unsigned fixed point
// (FRAC_W fractional bits), issued to the core over a start/done handshake,
// supervised with a timeout, and the result is returned with a done pulse.
//
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   clk_en            global enable; all registers hold while low
//   start, dataa      custom-instruction start pulse and IEEE-754 operand
//   done, result      one-cycle done pulse and {err, sign-ext core result}
//   core_start        one-cycle issue pulse to the CORDIC core
//   core_angle        fixed-point angle, stable from ISSUE until completion
//   core_done         core completion pulse (only honoured in WAIT)
//   core_result       core output, sampled with core_done
//
// Build option: define CORDIC_SEQ_CACHE_EN to add a one-entry result cache
// that answers a repeated operand without running the core.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; operand latched on start
// CONVERT  | float-to-fixed conversion registered into core_angle
// ISSUE    | core_start high, timeout counter cleared
// WAIT     | waiting for core_done or timeout
// DONE     | done high for one cycle with result

module cordic_ci_sequencer #(
    parameter int FRAC_W  = 13,
    parameter int RES_W   = 21,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                start,
    input  logic [31:0]         dataa,
    output logic                done,
    output logic [31:0]         result,
    output logic                core_start,
    output logic [8+FRAC_W-1:0] core_angle,
    input  logic                core_done,
    input  logic [RES_W-1:0]    core_result
);

    localparam int AW    = 8 + FRAC_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        op_q, op_d;
    logic [AW-1:0]      angle_q, angle_d;
    logic               core_start_q, core_start_d;
    logic               done_q, done_d;
    logic [31:0]        result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [AW-1:0]      conv_angle;
    logic [31:0]        core_fmt;

`ifdef CORDIC_SEQ_CACHE_EN
    logic               cache_vld_q, cache_vld_d;
    logic [31:0]        cache_op_q, cache_op_d;
    logic [31:0]        cache_res_q, cache_res_d;
`endif

    // Float to fixed. Exponents >= 135 mean the value is >= 256.0, so the
    // remaining normal range always right-shifts {m, FRAC_W zeros} and the
    // result fits in AW bits; shifts past the width give zero.
    logic [7:0]         conv_exp;
    logic [7:0]         conv_sh;
    logic [23+FRAC_W:0] conv_scaled;

    always_comb begin
        conv_exp    = op_q[30:23];
        conv_sh     = 8'(127 + 23) - conv_exp;
        conv_scaled = {1'b1, op_q[22:0], {FRAC_W{1'b0}}};
        if (conv_exp == 8'd0) begin
            conv_angle = '0;
        end else if (conv_exp == 8'hFF && op_q[22:0] != 23'd0) begin
            conv_angle = '1;
        end else if (op_q[31]) begin
            conv_angle = '0;
        end else if (conv_exp >= 8'(127 + 8)) begin
            conv_angle = '1;
        end else begin
            conv_angle = AW'(conv_scaled >> conv_sh);
        end
    end

    assign core_fmt = {1'b0, {(31-RES_W){core_result[RES_W-1]}}, core_result};
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        angle_d      = angle_q;
        core_start_d = 1'b0;
        done_d       = 1'b0;
        result_d     = result_q;
        cnt_d        = cnt_q;
`ifdef CORDIC_SEQ_CACHE_EN
        cache_vld_d  = cache_vld_q;
        cache_op_d   = cache_op_q;
        cache_res_d  = cache_res_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = dataa;
                    state_d = S_CONVERT;
`ifdef CORDIC_SEQ_CACHE_EN
                    if (cache_vld_q && dataa == cache_op_q) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = cache_res_q;
                    end
`endif
                end
            end
            S_CONVERT: begin
                angle_d      = conv_angle;
                core_start_d = 1'b1;
                state_d      = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // core_done takes priority over a timeout in the same cycle
                if (core_done) begin
                    result_d = core_fmt;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
`ifdef CORDIC_SEQ_CACHE_EN
                    cache_vld_d = 1'b1;
                    cache_op_d  = op_q;
                    cache_res_d = core_fmt;
`endif
                end else if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
                    result_d = 32'h8000_0000;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
`ifdef CORDIC_SEQ_CACHE_EN
                    cache_vld_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            angle_q      <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            cnt_q        <= '0;
`ifdef CORDIC_SEQ_CACHE_EN
            cache_vld_q  <= 1'b0;
            cache_op_q   <= '0;
            cache_res_q  <= '0;
`endif
        end else if (clk_en) begin
            state_q      <= state_d;
            op_q         <= op_d;
            angle_q      <= angle_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
`ifdef CORDIC_SEQ_CACHE_EN
            cache_vld_q  <= cache_vld_d;
            cache_op_q   <= cache_op_d;
            cache_res_q  <= cache_res_d;
`endif
        end
    end

    assign done       = done_q;
    assign result     = result_q;
    assign core_start = core_start_q;
    assign core_angle = angle_q;

endmodule

// File: tb/tb_cordic_ci_sequencer.sv
// Testbench for cordic_ci_sequencer: directed vectors plus a transaction-level
// reference model compared against the DUT on every negative clock edge.
module tb_cordic_ci_sequencer;

    localparam int FRAC_W  = 13;
    localparam int RES_W   = 21;
    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = 32'd0;
    logic        core_done = 1'b0;
    logic [20:0] core_result = 21'd0;
    logic        done;
    logic [31:0] result;
    logic        core_start;
    logic [20:0] core_angle;

    always #5 clock = ~clock;

    cordic_ci_sequencer #(.FRAC_W(FRAC_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa), .done(done), .result(result), .core_start(core_start),
        .core_angle(core_angle), .core_done(core_done), .core_result(core_result)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    int          ecyc = 0;     // index of the current enabled cycle
    bit          armed = 0;
    bit          m_busy = 0, m_wait = 0;
    int          cs_at = -1, done_at = -1, wait_from = 0, to_last = 0;
    int          ang_at = -1, res_at = -1;
    logic [20:0] m_angle = 0, ang_next = 0;
    logic [31:0] m_res = 0, res_next = 0, m_op = 0;
    bit          cvld = 0;
    logic [31:0] cop = 0, cres = 0;

    function automatic logic [20:0] f2fix(input logic [31:0] f);
        logic [10:0] ed;
        real r;
        if (f[30:23] == 8'd0) return 21'd0;
        if (f[30:23] == 8'hFF) return (f[22:0] != 0 || !f[31]) ? 21'h1FFFFF : 21'd0;
        if (f[31]) return 21'd0;
        ed = 11'(f[30:23]) + 11'd896;
        r = $bitstoreal({1'b0, ed, f[22:0], 29'd0});
        if (r >= 256.0) return 21'h1FFFFF;
        return 21'($rtoi(r * 8192.0));
    endfunction

    function automatic logic [31:0] fmt(input logic [20:0] r);
        logic signed [30:0] x;
        x = $signed(r);
        return {1'b0, x};
    endfunction

    initial begin : model
        int e;
        bit was;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_busy = 0; m_wait = 0; cs_at = -1; done_at = -1;
                ang_at = -1; res_at = -1; m_angle = 0; m_res = 0; cvld = 0;
                ecyc++;
                armed = 1;
            end else if (clk_en) begin
                e = ecyc;
                was = m_busy;
                if (!was && start) begin
                    m_op = dataa;
                    m_busy = 1;
`ifdef CORDIC_SEQ_CACHE_EN
                    if (cvld && dataa == cop) begin
                        done_at = e + 1; res_next = cres; res_at = e + 1;
                    end else
`endif
                    begin
                        cs_at = e + 2; ang_next = f2fix(dataa); ang_at = e + 2;
                        wait_from = e + 3; to_last = e + 1 + TIMEOUT; m_wait = 1;
                    end
                end
                if (m_wait && e >= wait_from) begin
                    if (core_done) begin
                        done_at = e + 1; res_next = fmt(core_result); res_at = e + 1;
                        m_wait = 0; cvld = 1; cop = m_op; cres = fmt(core_result);
                    end else if (e == to_last) begin
                        done_at = e + 1; res_next = 32'h8000_0000; res_at = e + 1;
                        m_wait = 0; cvld = 0;
                    end
                end
                if (was && e == done_at) m_busy = 0;
                ecyc++;
                if (ecyc == ang_at) m_angle = ang_next;
                if (ecyc == res_at) m_res = res_next;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, ecyc);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clock);
            if (armed) begin
                chk("model core_start", 32'(core_start), 32'(ecyc == cs_at));
                chk("model done", 32'(done), 32'(ecyc == done_at));
                chk("model core_angle", 32'(core_angle), 32'(m_angle));
                chk("model result", result, m_res);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_to(input int c);
        int g = 0;
        while (ecyc < c && g < 1000) begin
            @(negedge clock);
            g++;
        end
        if (ecyc < c) chk("run_to bound", 32'(ecyc), 32'(c));
    endtask

    task automatic op_start(input logic [31:0] f, output int s);
        s = ecyc;
        dataa = f;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_done(input int c, input logic [20:0] r);
        run_to(c);
        core_done = 1'b1;
        core_result = r;
        @(negedge clock);
        core_done = 1'b0;
    endtask

    logic [31:0] v_op  [8] = '{32'h437F0000, 32'h43800000, 32'hBF800000, 32'h00000000,
                               32'h7F800000, 32'h39000000, 32'h38800000, 32'h3F800000};
    logic [20:0] v_ang [8] = '{21'h1FE000, 21'h1FFFFF, 21'h000000, 21'h000000,
                               21'h1FFFFF, 21'h000001, 21'h000000, 21'h002000};
    logic [20:0] v_cr  [8] = '{21'h0ABCDE, 21'h1F0000, 21'h000001, 21'h000002,
                               21'h0FFFFF, 21'h100001, 21'h000003, 21'h012345};
    logic [31:0] v_res [8] = '{32'h000ABCDE, 32'h7FFF0000, 32'h00000001, 32'h00000002,
                               32'h000FFFFF, 32'h7FF00001, 32'h00000003, 32'h00012345};

    initial begin : stim
        int s;
        repeat (2) @(negedge clock);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        reset = 1'b0;

        // 25.0 with nominal latency
        op_start(32'h41C80000, s);
        run_to(s + 2);
        chk("t1 core_start", 32'(core_start), 32'd1);
        chk("t1 core_angle", 32'(core_angle), 32'h032000);
        pulse_done(s + 5, 21'h100000);
        chk("t1 done", 32'(done), 32'd1);
        chk("t1 result", result, 32'h7FF00000);
        @(negedge clock);
        chk("t1 done pulse width", 32'(done), 32'd0);

        // core_done in IDLE is ignored
        core_done = 1'b1;
        @(negedge clock);
        core_done = 1'b0;
        @(negedge clock);

        // conversion vectors at minimum latency
        for (int i = 0; i < 8; i++) begin
            op_start(v_op[i], s);
            run_to(s + 2);
            chk("t2 core_angle", 32'(core_angle), 32'(v_ang[i]));
            pulse_done(s + 3, v_cr[i]);
            chk("t2 done", 32'(done), 32'd1);
            chk("t2 result", result, v_res[i]);
            @(negedge clock);
        end

        // timeout, with a start during WAIT ignored
        op_start(32'h40000000, s);
        run_to(s + 10);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        run_to(s + 1 + TIMEOUT);
        chk("t3 no early done", 32'(done), 32'd0);
        run_to(s + 2 + TIMEOUT);
        chk("t3 timeout done", 32'(done), 32'd1);
        chk("t3 timeout result", result, 32'h80000000);
        @(negedge clock);

        // core_done in the timeout cycle wins
        op_start(32'h40400000, s);
        pulse_done(s + 1 + TIMEOUT, 21'h012345);
        chk("t3b done", 32'(done), 32'd1);
        chk("t3b result", result, 32'h00012345);
        @(negedge clock);

        // clk_en low during WAIT with an ignored core_done
        op_start(32'h40800000, s);
        run_to(s + 4);
        clk_en = 1'b0;
        @(negedge clock);
        core_done = 1'b1;
        core_result = 21'h00DEAD;
        @(negedge clock);
        core_done = 1'b0;
        repeat (3) @(negedge clock);
        chk("t4 held angle", 32'(core_angle), 32'h008000);
        chk("t4 held done", 32'(done), 32'd0);
        clk_en = 1'b1;
        pulse_done(s + 7, 21'h054321);
        chk("t4 done", 32'(done), 32'd1);
        chk("t4 result", result, 32'h00054321);
        @(negedge clock);

        // reset during WAIT
        op_start(32'h40A00000, s);
        run_to(s + 5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t5 done", 32'(done), 32'd0);
        chk("t5 core_start", 32'(core_start), 32'd0);
        chk("t5 core_angle", 32'(core_angle), 32'd0);
        chk("t5 result", result, 32'd0);
        repeat (3) @(negedge clock);
        op_start(32'h42480000, s);
        run_to(s + 2);
        chk("t5 angle 50.0", 32'(core_angle), 32'h064000);
        pulse_done(s + 3, 21'h000777);
        chk("t5 done", 32'(done), 32'd1);
        chk("t5 result", result, 32'h00000777);
        @(negedge clock);

`ifdef CORDIC_SEQ_CACHE_EN
        op_start(32'h42960000, s);
        pulse_done(s + 3, 21'h00CAFE);
        chk("t6 first result", result, 32'h0000CAFE);
        @(negedge clock);
        op_start(32'h42960000, s);
        chk("t6 hit done", 32'(done), 32'd1);
        chk("t6 hit result", result, 32'h0000CAFE);
        @(negedge clock);
        op_start(32'h3F800000, s);
        run_to(s + 2 + TIMEOUT);
        chk("t6 timeout result", result, 32'h80000000);
        @(negedge clock);
        op_start(32'h42960000, s);
        run_to(s + 2);
        chk("t6 reissue core_start", 32'(core_start), 32'd1);
        pulse_done(s + 3, 21'h000042);
        chk("t6 reissue result", result, 32'h00000042);
        @(negedge clock);
`endif

        repeat (4) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
